// File: rtl/nvme_pkg.sv
// Shared constants, state encoding and ring arithmetic for the NVMe SQ/CQ responder.
package nvme_pkg;

    localparam logic [31:0] SQ_BASE_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] CQ_BASE_DEFAULT = 32'h0000_1000;

    localparam int SQE_DWORDS    = 16;
    localparam int CQE_DWORDS    = 4;
    localparam int CQE_PHASE_BIT = 16;
    localparam int CQE_CID_W     = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DISPATCH,
        ST_WAIT_STS,
        ST_POST_WAIT,
        ST_POST
    } state_e;

    function automatic logic [7:0] ring_inc(input logic [7:0] idx, input int depth);
        return (idx == 8'(depth - 1)) ? 8'd0 : idx + 8'd1;
    endfunction

endpackage

// File: rtl/nvme_ring_ptr.sv
// Ring index with wrap at DEPTH; phase starts at 1 and flips on every wrap to 0.
// Index and phase update on the clock edge after inc.
module nvme_ring_ptr
    import nvme_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk_in,
    input  logic       resetb,
    input  logic       inc,
    output logic [7:0] idx,
    output logic       phase
);

    logic [7:0] idx_q, idx_d;
    logic       phase_q, phase_d;

    always_comb begin
        idx_d   = idx_q;
        phase_d = phase_q;
        if (inc) begin
            idx_d = ring_inc(idx_q, DEPTH);
            if (idx_q == 8'(DEPTH - 1)) begin
                phase_d = ~phase_q;
            end
        end
    end

    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            idx_q   <= 8'd0;
            phase_q <= 1'b1;
        end else begin
            idx_q   <= idx_d;
            phase_q <= phase_d;
        end
    end

    assign idx   = idx_q;
    assign phase = phase_q;

endmodule

// File: rtl/nvme_sq_cq_responder.sv
// Device-side SQ fetch / CQ post engine: one command in flight, 17-cycle fetch, 4-cycle post.
// Stalls in DISPATCH on cmd_ready, WAIT_STS on sts_valid, POST_WAIT while the CQ is full.
module nvme_sq_cq_responder
    import nvme_pkg::*;
#(
    parameter logic [31:0] SQ_BASE_ADDRESS = SQ_BASE_DEFAULT,
    parameter logic [31:0] CQ_BASE_ADDRESS = CQ_BASE_DEFAULT,
    parameter int          QUEUE_DEPTH     = 16,
    parameter logic [15:0] SQ_ID           = 16'd0
) (
    input  logic         clk_in,
    input  logic         resetb,
    input  logic         sq_tail_db_valid,
    input  logic [7:0]   sq_tail_db,
    input  logic         cq_head_db_valid,
    input  logic [7:0]   cq_head_db,
    output logic [31:0]  addrb,
    output logic [31:0]  dinb,
    input  logic [31:0]  doutb,
    output logic [3:0]   web,
    output logic         enb,
    output logic         cmd_valid,
    input  logic         cmd_ready,
    output logic [7:0]   cmd_opc,
    output logic [15:0]  cmd_cid,
    output logic [31:0]  cmd_nsid,
    output logic [63:0]  cmd_prp1,
    output logic [63:0]  cmd_prp2,
    output logic [191:0] cmd_cdw10_15,
    input  logic         sts_valid,
    output logic         sts_ready,
    input  logic [14:0]  sts_code,
    input  logic [31:0]  sts_dw0,
    output logic [7:0]   sq_head,
    output logic [7:0]   cq_tail,
    output logic         cq_phase,
    output logic         cqe_irq,
    output logic         db_err,
    output logic [15:0]  cmd_cnt
);

    state_e         state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [7:0]     sq_tail_q, sq_tail_d, cq_head_q, cq_head_d;
    logic           db_err_q, db_err_d, irq_q, irq_d;
    logic [31:0]    addr_q, addr_d;
    logic [15:0]    cmd_cnt_q, cmd_cnt_d;
    logic [7:0]     opc_q, opc_d;
    logic [15:0]    cid_q, cid_d;
    logic [31:0]    nsid_q, nsid_d;
    logic [63:0]    prp1_q, prp1_d, prp2_q, prp2_d;
    logic [191:0]   cdw_q, cdw_d;
    logic [14:0]    code_q, code_d;
    logic [31:0]    res_q, res_d;
    logic [4:0]     cap_idx;
    logic [31:0]    cqe_dw3;
    logic           sq_inc, cq_inc, cq_full, sq_phase_unused;

    nvme_ring_ptr #(.DEPTH(QUEUE_DEPTH)) u_sq_head (
        .clk_in (clk_in), .resetb (resetb), .inc (sq_inc),
        .idx    (sq_head), .phase (sq_phase_unused)
    );

    nvme_ring_ptr #(.DEPTH(QUEUE_DEPTH)) u_cq_tail (
        .clk_in (clk_in), .resetb (resetb), .inc (cq_inc),
        .idx    (cq_tail), .phase (cq_phase)
    );

    assign cq_full = (ring_inc(cq_tail, QUEUE_DEPTH) == cq_head_q);
    assign cap_idx = cnt_q - 5'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sq_tail_d = sq_tail_q;
        cq_head_d = cq_head_q;
        db_err_d  = db_err_q;
        irq_d     = 1'b0;
        cmd_cnt_d = cmd_cnt_q;
        opc_d     = opc_q;
        cid_d     = cid_q;
        nsid_d    = nsid_q;
        prp1_d    = prp1_q;
        prp2_d    = prp2_q;
        cdw_d     = cdw_q;
        code_d    = code_q;
        res_d     = res_q;
        addr_d    = addr_q;
        sq_inc    = 1'b0;
        cq_inc    = 1'b0;
        enb       = 1'b0;
        web       = 4'h0;
        dinb      = 32'h0;
        cmd_valid = 1'b0;
        sts_ready = 1'b0;

        cqe_dw3                                = 32'h0;
        cqe_dw3[CQE_CID_W-1:0]                 = cid_q;
        cqe_dw3[CQE_PHASE_BIT]                 = cq_phase;
        cqe_dw3[31:CQE_PHASE_BIT+1]            = code_q;

        if (sq_tail_db_valid) begin
            if ({1'b0, sq_tail_db} < 9'(QUEUE_DEPTH)) sq_tail_d = sq_tail_db;
            else                                      db_err_d  = 1'b1;
        end
        if (cq_head_db_valid) begin
            if ({1'b0, cq_head_db} < 9'(QUEUE_DEPTH)) cq_head_d = cq_head_db;
            else                                      db_err_d  = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (sq_head != sq_tail_q) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (cnt_q < 5'(SQE_DWORDS)) begin
                    enb    = 1'b1;
                    addr_d = SQ_BASE_ADDRESS + 32'({sq_head, 6'b0}) + 32'({cnt_q, 2'b0});
                end
                // read data trails its address by one cycle
                if (cnt_q != 5'd0) begin
                    case (cap_idx)
                        5'd0:  begin opc_d = doutb[7:0]; cid_d = doutb[31:16]; end
                        5'd1:  nsid_d         = doutb;
                        5'd6:  prp1_d[31:0]   = doutb;
                        5'd7:  prp1_d[63:32]  = doutb;
                        5'd8:  prp2_d[31:0]   = doutb;
                        5'd9:  prp2_d[63:32]  = doutb;
                        5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15:
                            cdw_d[32*(int'(cap_idx) - 10) +: 32] = doutb;
                        default: ;
                    endcase
                end
                if (cnt_q == 5'(SQE_DWORDS)) begin
                    cnt_d   = 5'd0;
                    sq_inc  = 1'b1;
                    state_d = ST_DISPATCH;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            ST_DISPATCH: begin
                cmd_valid = 1'b1;
                if (cmd_ready) state_d = ST_WAIT_STS;
            end
            ST_WAIT_STS: begin
                sts_ready = 1'b1;
                if (sts_valid) begin
                    code_d  = sts_code;
                    res_d   = sts_dw0;
                    state_d = ST_POST_WAIT;
                end
            end
            ST_POST_WAIT: begin
                if (!cq_full) state_d = ST_POST;
            end
            ST_POST: begin
                enb    = 1'b1;
                web    = 4'hf;
                addr_d = CQ_BASE_ADDRESS + 32'({cq_tail, 4'b0}) + 32'({cnt_q, 2'b0});
                // DW3 carries the phase tag, so it must land last
                case (cnt_q)
                    5'd0:    dinb = res_q;
                    5'd1:    dinb = 32'h0;
                    5'd2:    dinb = {SQ_ID, 8'h00, sq_head};
                    default: dinb = cqe_dw3;
                endcase
                if (cnt_q == 5'(CQE_DWORDS - 1)) begin
                    cnt_d     = 5'd0;
                    cq_inc    = 1'b1;
                    irq_d     = 1'b1;
                    cmd_cnt_d = cmd_cnt_q + 16'd1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 5'd0;
            sq_tail_q <= 8'd0;
            cq_head_q <= 8'd0;
            db_err_q  <= 1'b0;
            irq_q     <= 1'b0;
            cmd_cnt_q <= 16'd0;
            addr_q    <= 32'h0;
            opc_q     <= 8'h0;
            cid_q     <= 16'h0;
            nsid_q    <= 32'h0;
            prp1_q    <= 64'h0;
            prp2_q    <= 64'h0;
            cdw_q     <= 192'h0;
            code_q    <= 15'h0;
            res_q     <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sq_tail_q <= sq_tail_d;
            cq_head_q <= cq_head_d;
            db_err_q  <= db_err_d;
            irq_q     <= irq_d;
            cmd_cnt_q <= cmd_cnt_d;
            addr_q    <= addr_d;
            opc_q     <= opc_d;
            cid_q     <= cid_d;
            nsid_q    <= nsid_d;
            prp1_q    <= prp1_d;
            prp2_q    <= prp2_d;
            cdw_q     <= cdw_d;
            code_q    <= code_d;
            res_q     <= res_d;
        end
    end

    assign addrb        = addr_d;
    assign cmd_opc      = opc_q;
    assign cmd_cid      = cid_q;
    assign cmd_nsid     = nsid_q;
    assign cmd_prp1     = prp1_q;
    assign cmd_prp2     = prp2_q;
    assign cmd_cdw10_15 = cdw_q;
    assign cqe_irq      = irq_q;
    assign db_err       = db_err_q;
    assign cmd_cnt      = cmd_cnt_q;

endmodule

// File: tb/tb_nvme_sq_cq_responder.sv
// Directed-plus-random bench for nvme_sq_cq_responder with a queue-level reference model.
module tb_nvme_sq_cq_responder;

    localparam int          QD   = 16;
    localparam logic [31:0] CQB  = 32'h0000_1000;
    localparam logic [15:0] SQID = 16'h0000;

    logic         clk_in = 1'b0;
    logic         resetb = 1'b1;
    logic         sq_tail_db_valid = 1'b0, cq_head_db_valid = 1'b0;
    logic [7:0]   sq_tail_db = 8'h0, cq_head_db = 8'h0;
    logic [31:0]  addrb, dinb;
    logic [31:0]  doutb = 32'h0;
    logic [3:0]   web;
    logic         enb, cmd_valid, sts_ready, cqe_irq, db_err, cq_phase;
    logic         cmd_ready = 1'b0, sts_valid = 1'b0;
    logic [7:0]   cmd_opc, sq_head, cq_tail;
    logic [15:0]  cmd_cid, cmd_cnt;
    logic [31:0]  cmd_nsid;
    logic [63:0]  cmd_prp1, cmd_prp2;
    logic [191:0] cmd_cdw10_15;
    logic [14:0]  sts_code = 15'h0;
    logic [31:0]  sts_dw0 = 32'h0;

    nvme_sq_cq_responder #(.QUEUE_DEPTH(QD), .SQ_ID(SQID)) dut (
        .clk_in (clk_in), .resetb (resetb),
        .sq_tail_db_valid (sq_tail_db_valid), .sq_tail_db (sq_tail_db),
        .cq_head_db_valid (cq_head_db_valid), .cq_head_db (cq_head_db),
        .addrb (addrb), .dinb (dinb), .doutb (doutb), .web (web), .enb (enb),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_opc (cmd_opc),
        .cmd_cid (cmd_cid), .cmd_nsid (cmd_nsid), .cmd_prp1 (cmd_prp1),
        .cmd_prp2 (cmd_prp2), .cmd_cdw10_15 (cmd_cdw10_15),
        .sts_valid (sts_valid), .sts_ready (sts_ready), .sts_code (sts_code),
        .sts_dw0 (sts_dw0), .sq_head (sq_head), .cq_tail (cq_tail),
        .cq_phase (cq_phase), .cqe_irq (cqe_irq), .db_err (db_err), .cmd_cnt (cmd_cnt)
    );

    always #5 clk_in = ~clk_in;

    // Shared queue memory: SQ region filled by the host side, CQ region written by the DUT.
    logic [31:0] sq_mem [0:1023];
    logic [31:0] cq_mem [0:63];
    int          wr_cnt = 0, irq_cnt = 0;
    logic [31:0] last_wr = 32'h0;

    always @(posedge clk_in) begin
        if (enb) begin
            if (web != 4'h0) begin
                cq_mem[addrb[7:2]] <= dinb;
                wr_cnt             <= wr_cnt + 1;
                last_wr            <= addrb;
            end
            doutb <= sq_mem[addrb[11:2]];
        end
        if (cqe_irq) irq_cnt <= irq_cnt + 1;
    end

    int n_assert = 0, n_fail = 0;
    int m_sq_tail, m_sq_head, m_cq_tail, m_cnt, wr_base;
    logic        m_phase;
    logic [15:0] m_cid;
    logic [14:0] m_code;
    logic [31:0] m_dw0;
    logic [31:0] sqe [16];

    task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sq_tail = 0; m_sq_head = 0; m_cq_tail = 0; m_cnt = 0; m_phase = 1'b1;
    endtask

    task automatic ring_sq(input logic [7:0] v);
        @(negedge clk_in); sq_tail_db_valid = 1'b1; sq_tail_db = v;
        @(negedge clk_in); sq_tail_db_valid = 1'b0;
    endtask

    task automatic ring_cq(input logic [7:0] v);
        @(negedge clk_in); cq_head_db_valid = 1'b1; cq_head_db = v;
        @(negedge clk_in); cq_head_db_valid = 1'b0;
    endtask

    task automatic rand_sqe();
        for (int k = 0; k < 16; k++) sqe[k] = $urandom;
    endtask

    function automatic logic [383:0] exp_fields();
        return {8'(sqe[0]), sqe[0][31:16], sqe[1], sqe[7], sqe[6], sqe[9], sqe[8],
                sqe[15], sqe[14], sqe[13], sqe[12], sqe[11], sqe[10]};
    endfunction

    function automatic logic [383:0] obs_fields();
        return {cmd_opc, cmd_cid, cmd_nsid, cmd_prp1, cmd_prp2, cmd_cdw10_15};
    endfunction

    task automatic issue(input int rdy_dly);
        bit seen;
        for (int k = 0; k < 16; k++) sq_mem[m_sq_tail*16 + k] = sqe[k];
        m_cid     = sqe[0][31:16];
        m_sq_tail = (m_sq_tail + 1) % QD;
        ring_sq(8'(m_sq_tail));
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk_in);
            if (cmd_valid) seen = 1;
        end
        check("cmd_valid_wait", 384'(seen), 384'(1));
        m_sq_head = (m_sq_head + 1) % QD;
        check("cmd_fields", obs_fields(), exp_fields());
        check("sq_head_dispatch", 384'(sq_head), 384'(m_sq_head));
        for (int i = 0; i < rdy_dly; i++) begin
            @(negedge clk_in);
            check("hold_valid_noenb", 384'({cmd_valid, enb}), 384'(2'b10));
            check("hold_fields", obs_fields(), exp_fields());
        end
        cmd_ready = 1'b1;
        @(negedge clk_in);
        cmd_ready = 1'b0;
    endtask

    task automatic give_status(input logic [14:0] code, input logic [31:0] dw0);
        bit seen;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (sts_ready) seen = 1;
            else @(negedge clk_in);
        end
        check("sts_ready_wait", 384'(seen), 384'(1));
        m_code = code; m_dw0 = dw0; wr_base = wr_cnt;
        sts_valid = 1'b1; sts_code = code; sts_dw0 = dw0;
        @(negedge clk_in);
        sts_valid = 1'b0;
    endtask

    task automatic complete(input bit keep_cq);
        bit seen;
        int base;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk_in);
            if (cqe_irq) seen = 1;
        end
        check("cqe_irq_wait", 384'(seen), 384'(1));
        base = m_cq_tail * 4;
        check("cqe_writes", 384'(wr_cnt - wr_base), 384'(4));
        check("cqe_body", {cq_mem[base], cq_mem[base+1], cq_mem[base+2], cq_mem[base+3]},
              {m_dw0, 32'h0, SQID, 8'h00, 8'(m_sq_head), m_code, m_phase, m_cid});
        check("cqe_dw3_last", 384'(last_wr), 384'(CQB + 32'(m_cq_tail*16 + 12)));
        m_cq_tail = (m_cq_tail + 1) % QD;
        if (m_cq_tail == 0) m_phase = ~m_phase;
        m_cnt++;
        check("counters", {cq_tail, cq_phase, cmd_cnt, sq_head},
              {8'(m_cq_tail), m_phase, 16'(m_cnt), 8'(m_sq_head)});
        @(negedge clk_in);
        check("irq_one_cycle", 384'(cqe_irq), 384'(0));
        if (keep_cq) ring_cq(8'(m_cq_tail));
    endtask

    task automatic quiet(input int n);
        int act;
        act = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            if (enb || cmd_valid) act++;
        end
        check("quiet", 384'(act), 384'(0));
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 1024; i++) sq_mem[i] = 32'h0;
        model_reset();

        // reset values
        #1 resetb = 1'b0;
        #1;
        check("reset_outputs", {sq_head, cq_tail, cq_phase, cmd_valid, sts_ready, cqe_irq,
                                db_err, enb, web, cmd_cnt},
              {8'h0, 8'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0});
        check("reset_cmd_data", obs_fields(), 384'(0));
        repeat (2) @(negedge clk_in);
        resetb = 1'b1;

        // first command, directed values
        rand_sqe();
        sqe[0] = 32'h0005_0006;
        issue(0);
        give_status(15'h0, 32'h0000_00A5);
        complete(1'b1);
        check("t1_cqe", {cq_mem[0], cq_mem[1], cq_mem[2], cq_mem[3]},
              {32'h0000_00A5, 32'h0, 32'h0000_0001, 32'h0001_0005});

        // out-of-range SQ tail doorbell
        ring_sq(8'd20);
        quiet(20);
        check("db_err_set", {db_err, sq_head}, {1'b1, 8'(m_sq_head)});

        // backend holds off cmd_ready; tail register must still be 1
        rand_sqe();
        issue(10);
        give_status(15'($urandom), $urandom);
        complete(1'b1);
        quiet(20);

        // run through the CQ wrap and one entry beyond with head kept current
        while (m_cnt < 17) begin
            rand_sqe();
            issue(int'($urandom_range(0, 3)));
            give_status(15'($urandom), $urandom);
            complete(1'b1);
            if (m_cnt == 16) check("wrap_tail_phase", {cq_tail, cq_phase}, {8'h0, 1'b0});
        end

        // reset during POST, after the DW1 write
        rand_sqe();
        issue(0);
        give_status(15'($urandom), $urandom);
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk_in);
            if (enb && web == 4'hf && addrb == CQB + 32'(m_cq_tail*16 + 8)) seen = 1;
        end
        check("dw2_cycle_wait", 384'(seen), 384'(1));
        resetb = 1'b0;
        #1;
        check("midpost_reset", {web, enb, cmd_valid, sts_ready, cq_tail, cq_phase, sq_head,
                                db_err, cmd_cnt},
              {4'h0, 1'b0, 1'b0, 1'b0, 8'h0, 1'b1, 8'h0, 1'b0, 16'h0});
        @(negedge clk_in);
        resetb = 1'b1;
        model_reset();
        quiet(5);
        check("post_release", {cq_phase, cq_tail}, {1'b1, 8'h0});

        // CQ head stuck at 0: fifteen CQEs fit, the sixteenth stalls
        for (int n = 0; n < 15; n++) begin
            rand_sqe();
            issue(0);
            give_status(15'($urandom), $urandom);
            complete(1'b0);
        end
        rand_sqe();
        issue(0);
        give_status(15'($urandom), $urandom);
        begin
            int irq_base;
            irq_base = irq_cnt;
            repeat (20) @(negedge clk_in);
            check("stall_no_write", {32'(wr_cnt - wr_base), 32'(irq_cnt - irq_base), 8'(cq_tail), enb},
                  {32'h0, 32'h0, 8'd15, 1'b0});
        end
        ring_cq(8'd1);
        seen = 0;
        for (int i = 0; i < 2 && !seen; i++) begin
            if (enb && web == 4'hf) seen = 1;
            else @(negedge clk_in);
        end
        check("unstall_within_2", 384'(seen), 384'(1));
        complete(1'b0);
        check("stall_wrap", {cq_tail, cq_phase}, {8'h0, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
